// File: rtl/camera_capture.sv
// camera_capture: byte-pair pixel capture from an RGB444 camera port.
// Writes assembled pixels into a frame buffer, one frame per vsync period.
module camera_capture #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 76800,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             vsync_i,
  input  logic             href_i,
  input  logic [7:0]       data_i,
  output logic             write_en_o,
  output logic [AW-1:0]    write_address_o,
  output logic [WIDTH-1:0] write_data_o,
  output logic             frame_done_o,
  output logic             overflow_o,
  output logic [7:0]       frame_count_o
);

  // pointer is one bit wider so it can sit at DEPTH
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             phase_q, phase_d;
  logic [3:0]       hi_q, hi_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  // next-state, byte pairing and write strobe generation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i && vsync_i) state_d = SYNC;
      end
      SYNC: begin
        if (!vsync_i) begin
          state_d = ACTIVE;
          ptr_d   = '0;
          phase_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (vsync_i) begin
          // frame end beats any byte in flight
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          phase_d = 1'b0;
          state_d = enable_i ? SYNC : IDLE;
        end else if (!href_i) begin
          phase_d = 1'b0;
        end else if (!phase_q) begin
          hi_d    = data_i[3:0];
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (ptr_q == PW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = ptr_q[AW-1:0];
            data_d = WIDTH'({hi_q, data_i});
            ptr_d  = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign write_en_o      = we_q;
  assign write_address_o = addr_q;
  assign write_data_o    = data_q;
  assign frame_done_o    = done_q;
  assign overflow_o      = ovf_q;
  assign frame_count_o   = cnt_q;

endmodule
